// File: rtl/quadrilatero_multi_sa_issue_controller.sv
// rtl/quadrilatero_multi_sa_issue_controller.sv - in-order SA issue queue with round-robin array arbitration
//
// Buffers dispatched systolic-array instructions in a circular queue and
// issues the head entry, one per cycle, to the next ready weight-load stage
// in round-robin order.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             discard all queued instructions
//   dispatch_i          push request, dispatched_instr_i is the payload
//   full_o              early-full (usage >= N_SLOTS - FULL_MARGIN)
//   empty_o, usage_o    occupancy flags / count (0..N_SLOTS)
//   overflow_o          sticky, set when a push is dropped; cleared by reset only
//   wl_ready_i          per-array weight-load ready
//   start_o             one-hot issue strobe per array
//   issued_instr_o      head-of-queue instruction, shared by all arrays

package quadrilatero_pkg;
    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] arg;
    } sa_instr_t;
endpackage

module quadrilatero_multi_sa_issue_controller #(
    parameter int N_SLOTS     = 4,
    parameter int N_SA        = 2,
    parameter int FULL_MARGIN = 1,
    localparam int USAGE_W    = $clog2(N_SLOTS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        dispatch_i,
    input  quadrilatero_pkg::sa_instr_t dispatched_instr_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [USAGE_W-1:0]          usage_o,
    output logic                        overflow_o,
    input  logic [N_SA-1:0]             wl_ready_i,
    output logic [N_SA-1:0]             start_o,
    output quadrilatero_pkg::sa_instr_t issued_instr_o
);

    localparam int PTR_W = $clog2(N_SLOTS);
    localparam int RR_W  = (N_SA > 1) ? $clog2(N_SA) : 1;

    localparam logic [USAGE_W-1:0] DEPTH       = USAGE_W'(N_SLOTS);
    localparam logic [USAGE_W-1:0] FULL_THRESH = USAGE_W'(N_SLOTS - FULL_MARGIN);
    localparam logic [PTR_W-1:0]   LAST_SLOT   = PTR_W'(N_SLOTS - 1);
    localparam logic [RR_W-1:0]    LAST_SA     = RR_W'(N_SA - 1);

    quadrilatero_pkg::sa_instr_t mem [N_SLOTS];

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [USAGE_W-1:0] count;
    logic [RR_W-1:0]    rr_ptr;
    logic               overflow;

    logic               grant_found;
    logic [RR_W-1:0]    grant_idx;
    logic [RR_W-1:0]    scan_idx;
    logic               pop;
    logic               push_ok;
    logic               drop;

    // Scan ready bits starting at rr_ptr, wrapping modulo N_SA; first hit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < N_SA; i++) begin
            scan_idx = RR_W'((int'(rr_ptr) + i) % N_SA);
            if (!grant_found && wl_ready_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Reset and flush both mask issue in their own cycle.
    always_comb begin
        pop     = (count != '0) && grant_found && !flush_i && !rst_i;
        // A push at full is still accepted when the head leaves the same cycle.
        push_ok = dispatch_i && !flush_i && ((count != DEPTH) || pop);
        drop    = dispatch_i && !flush_i && (count == DEPTH) && !pop;
        start_o = '0;
        if (pop) begin
            start_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            // rr_ptr and overflow deliberately survive a flush.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= dispatched_instr_i;
                wr_ptr      <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_W'(1);
                rr_ptr <= (grant_idx == LAST_SA) ? '0 : grant_idx + RR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + USAGE_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - USAGE_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign full_o         = (count >= FULL_THRESH);
    assign empty_o        = (count == '0);
    assign usage_o        = count;
    assign overflow_o     = overflow;
    assign issued_instr_o = mem[rd_ptr];

endmodule

// File: tb/tb_quadrilatero_multi_sa_issue_controller.sv
// tb/tb_quadrilatero_multi_sa_issue_controller.sv - directed self-checking bench for the SA issue controller
module tb_quadrilatero_multi_sa_issue_controller;

    import quadrilatero_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            dispatch = 1'b0;
    sa_instr_t       instr = '0;
    logic            full;
    logic            empty;
    logic [2:0]      usage;
    logic            overflow;
    logic [2:0]      ready = 3'b000;
    logic [2:0]      start;
    sa_instr_t       issued;

    int total = 0;
    int bad   = 0;

    quadrilatero_multi_sa_issue_controller #(
        .N_SLOTS(4),
        .N_SA(3),
        .FULL_MARGIN(1)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .dispatch_i(dispatch),
        .dispatched_instr_i(instr),
        .full_o(full),
        .empty_o(empty),
        .usage_o(usage),
        .overflow_o(overflow),
        .wl_ready_i(ready),
        .start_o(start),
        .issued_instr_o(issued)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; dispatch = 1'b0; ready = 3'b000; instr = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (usage !== 3'd0) begin bad++; $display("FAIL reset_usage got=%0d exp=0", usage); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (start !== 3'b000) begin bad++; $display("FAIL reset_start got=%b exp=000", start); end
        total++; if (issued !== 16'h0000) begin bad++; $display("FAIL reset_issued got=%h exp=0000", issued); end
    endtask

    task automatic test_fill_flags();
        ready = 3'b000;
        for (int k = 0; k < 4; k++) begin
            dispatch = 1'b1;
            instr = sa_instr_t'(16'hA000 + 16'(k));
            tick();
            total++; if (usage !== 3'(k + 1)) begin bad++; $display("FAIL fill_usage[%0d] got=%0d exp=%0d", k, usage, k + 1); end
            total++; if (full !== (k + 1 >= 3)) begin bad++; $display("FAIL fill_full[%0d] got=%b exp=%b", k, full, (k + 1 >= 3)); end
            total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty[%0d] got=%b exp=0", k, empty); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_overflow[%0d] got=%b exp=0", k, overflow); end
        end
        dispatch = 1'b0;
    endtask

    task automatic test_overflow();
        dispatch = 1'b1;
        instr = sa_instr_t'(16'hE000);
        ready = 3'b000;
        #1;
        total++; if (start !== 3'b000) begin bad++; $display("FAIL ovf_start got=%b exp=000", start); end
        tick();
        dispatch = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (usage !== 3'd4) begin bad++; $display("FAIL ovf_usage got=%0d exp=4", usage); end
        ready = 3'b001;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++; if (start !== 3'b001) begin bad++; $display("FAIL ovf_drain_start[%0d] got=%b exp=001", k, start); end
            total++; if (issued !== sa_instr_t'(16'hA000 + 16'(k))) begin bad++; $display("FAIL ovf_drain_instr[%0d] got=%h exp=%h", k, issued, 16'hA000 + 16'(k)); end
            tick();
            total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky[%0d] got=%b exp=1", k, overflow); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b exp=1", empty); end
        total++; if (start !== 3'b000) begin bad++; $display("FAIL ovf_no_e_start got=%b exp=000", start); end
        ready = 3'b000;
    endtask

    // Also covers push-at-full with a same-cycle pop (I4, I5).
    task automatic test_round_robin();
        logic [2:0] rdy_seq [6];
        logic [2:0] exp_seq [6];
        rdy_seq = '{3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b101};
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            dispatch = 1'b1;
            instr = sa_instr_t'(16'hB000 + 16'(k));
            tick();
        end
        dispatch = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ready = rdy_seq[k];
            dispatch = (k < 2);
            instr = sa_instr_t'(16'hB000 + 16'(k + 4));
            #1;
            total++; if (start !== exp_seq[k]) begin bad++; $display("FAIL rr_start[%0d] got=%b exp=%b", k, start, exp_seq[k]); end
            total++; if (issued !== sa_instr_t'(16'hB000 + 16'(k))) begin bad++; $display("FAIL rr_instr[%0d] got=%h exp=%h", k, issued, 16'hB000 + 16'(k)); end
            tick();
            if (k < 2) begin
                total++; if (usage !== 3'd4) begin bad++; $display("FAIL rr_full_pushpop_usage[%0d] got=%0d exp=4", k, usage); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rr_full_pushpop_ovf[%0d] got=%b exp=0", k, overflow); end
            end
        end
        dispatch = 1'b0;
        ready = 3'b000;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rr_empty got=%b exp=1", empty); end
    endtask

    task automatic test_flush();
        // rr_ptr is 1 here (last grant was array 0).
        for (int k = 0; k < 5; k++) begin
            dispatch = 1'b1;
            instr = sa_instr_t'(16'hC000 + 16'(k));
            tick();
        end
        dispatch = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL flush_pre_ovf got=%b exp=1", overflow); end
        ready = 3'b001;
        #1;
        total++; if (start !== 3'b001) begin bad++; $display("FAIL flush_pre_pop got=%b exp=001", start); end
        tick();
        total++; if (usage !== 3'd3) begin bad++; $display("FAIL flush_pre_usage got=%0d exp=3", usage); end
        flush = 1'b1; dispatch = 1'b1; ready = 3'b111;
        instr = sa_instr_t'(16'hCFFF);
        #1;
        total++; if (start !== 3'b000) begin bad++; $display("FAIL flush_start got=%b exp=000", start); end
        tick();
        flush = 1'b0; dispatch = 1'b0; ready = 3'b000;
        total++; if (usage !== 3'd0) begin bad++; $display("FAIL flush_usage got=%0d exp=0", usage); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b exp=1", empty); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL flush_ovf got=%b exp=1", overflow); end
        dispatch = 1'b1; ready = 3'b111;
        instr = sa_instr_t'(16'hD00D);
        #1;
        total++; if (start !== 3'b000) begin bad++; $display("FAIL flush_no_fallthru got=%b exp=000", start); end
        tick();
        dispatch = 1'b0;
        #1;
        total++; if (start !== 3'b010) begin bad++; $display("FAIL flush_rr_start got=%b exp=010", start); end
        total++; if (issued !== 16'hD00D) begin bad++; $display("FAIL flush_rr_instr got=%h exp=d00d", issued); end
        tick();
        ready = 3'b000;
    endtask

    task automatic test_mid_reset();
        // rr_ptr is 2 here; reset must bring it back to 0.
        for (int k = 0; k < 2; k++) begin
            dispatch = 1'b1;
            instr = sa_instr_t'(16'hF000 + 16'(k));
            tick();
        end
        total++; if (usage !== 3'd2) begin bad++; $display("FAIL mrst_pre_usage got=%0d exp=2", usage); end
        rst = 1'b1; dispatch = 1'b1; ready = 3'b111;
        instr = sa_instr_t'(16'hFFFF);
        #1;
        total++; if (start !== 3'b000) begin bad++; $display("FAIL mrst_start got=%b exp=000", start); end
        tick();
        rst = 1'b0; dispatch = 1'b0; ready = 3'b000;
        #1;
        total++; if (usage !== 3'd0) begin bad++; $display("FAIL mrst_usage got=%0d exp=0", usage); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL mrst_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL mrst_full got=%b exp=0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mrst_ovf got=%b exp=0", overflow); end
        total++; if (issued !== 16'h0000) begin bad++; $display("FAIL mrst_issued got=%h exp=0000", issued); end
        total++; if (start !== 3'b000) begin bad++; $display("FAIL mrst_idle_start got=%b exp=000", start); end
        tick();
        dispatch = 1'b1; ready = 3'b111;
        instr = sa_instr_t'(16'h1234);
        tick();
        dispatch = 1'b0;
        #1;
        total++; if (start !== 3'b001) begin bad++; $display("FAIL mrst_rr_start got=%b exp=001", start); end
        total++; if (issued !== 16'h1234) begin bad++; $display("FAIL mrst_rr_instr got=%h exp=1234", issued); end
        tick();
        ready = 3'b000;
    endtask

    initial begin
        test_reset();
        test_fill_flags();
        test_overflow();
        test_round_robin();
        test_flush();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quadrilatero_multi_sa_issue_controller.md
# quadrilatero_multi_sa_issue_controller

In-order issue controller that buffers dispatched systolic-array instructions in an internal circular queue and issues them, one per cycle, to one of `N_SA` systolic-array weight-load (WL) stages using round-robin arbitration. It sits between the dispatcher and a bank of systolic arrays. It adds the following:
- a configurable early-full margin,
- synchronous flush,
- an occupancy count that can represent a completely full queue,
- a sticky overflow flag.

## Interface
- `N_SLOTS`, default 4: queue depth in instructions; must be ≥ 2.
- `N_SA`, default 2: number of systolic arrays served; must be ≥ 1.
- `FULL_MARGIN`, default 1: `full_o` asserts when usage ≥ `N_SLOTS - FULL_MARGIN`; legal range is 0 ≤ `FULL_MARGIN` < `N_SLOTS`.
- `USAGE_W`, derived as `$clog2(N_SLOTS+1)`; not overridable.
- `clk_i`, input, 1 bit: the single clock. All state updates on the rising edge.
- `rst_i`, input, 1 bit: reset, synchronous and active-high.
- `flush_i`, input, 1 bit: synchronously discards all queued instructions.
- `dispatch_i`, input, 1 bit: push request from the dispatcher.
- `dispatched_instr_i`, input, `quadrilatero_pkg::sa_instr_t`: instruction to push.
- `full_o`, output, 1 bit: early-full indication to the dispatcher.
- `empty_o`, output, 1 bit: queue holds no instructions.
- `usage_o`, output, `USAGE_W` bits: current occupancy, 0..`N_SLOTS`.
- `overflow_o`, output, 1 bit: sticky flag, set when a push is dropped.
- `wl_ready_i`, input, `N_SA` bits: per-array WL stage ready.
- `start_o`, output, `N_SA` bits: one-hot issue strobe; bit k means array k starts executing `issued_instr_o` this cycle.
- `issued_instr_o`, output, `quadrilatero_pkg::sa_instr_t`: head-of-queue instruction, shared by all arrays.

## Operation
- **Storage:** `N_SLOTS` entries held in registers, with read pointer, write pointer and count registers. Pointers wrap from `N_SLOTS-1` to 0. `N_SLOTS` need not be a power of two.
- **Push acceptance:** a push is accepted when `dispatch_i` is high and either:
  - count < `N_SLOTS`, or
  - count == `N_SLOTS` and a pop occurs in the same cycle.

  An accepted push writes the entry at the write pointer and advances it.
- **Dropped push:** `dispatch_i` high with count == `N_SLOTS` and no pop. The data is discarded, the queue state is unchanged, and `overflow_o` is set. `overflow_o` clears only on reset, not on flush.
- **No fall-through:** an instruction pushed in cycle t is visible at the head, and issuable, no earlier than cycle t+1.
- **Pop / issue:** occurs when the queue is not empty and at least one bit of `wl_ready_i` is set.
  - **Arbitration:** the grant goes to the first ready index found by scanning from `rr_ptr` upward, modulo `N_SA`.
  - **Pop effects:** `start_o` is one-hot at the granted index. The read pointer advances and `rr_ptr` becomes (granted index + 1) mod `N_SA`.
  - **No pop:** `rr_ptr` holds and `start_o` = 0.
- **Count update:** count += push accepted, count −= pop; both in the same cycle leave count unchanged.
- **Flush:**
  - Pointers and count reset to 0 at the next edge.
  - `start_o` is still 0 in the flush cycle: flush masks issue combinationally.
  - A same-cycle push is discarded and does not set overflow.
  - `rr_ptr` is preserved.
- **Flag definitions:** `full_o` = (count ≥ `N_SLOTS - FULL_MARGIN`). `empty_o` = (count == 0). `usage_o` = count.
- **`issued_instr_o`:** always shows the entry at the read pointer. It is meaningful only when some `start_o` bit is set.
- **Priority when events coincide:** `rst_i` > `flush_i` > push/pop.

## Timing
- **Reset values** (after any edge with `rst_i`=1):
  - pointers, count and `rr_ptr` = 0; storage = '0
  - `start_o` = 0, `usage_o` = 0, `empty_o` = 1, `overflow_o` = 0, `issued_instr_o` = '0
  - `full_o` = 0 (since `FULL_MARGIN` < `N_SLOTS`)
- **Reset mid-operation:** all queued instructions are lost. No `start_o` is asserted in the reset cycle.
- **Combinational paths:**
  - `start_o` depends combinationally on `wl_ready_i`, `flush_i`, `rst_i` and registered state only.
  - `full_o`, `empty_o`, `usage_o` and `issued_instr_o` come purely from registers.
  - There is no combinational path from `dispatch_i` or `dispatched_instr_i` to any output.
- **Minimum latency:** dispatch in cycle t leads to start in cycle t+1.
- **Sustained throughput:** one issue per cycle while any array is ready and the queue is non-empty.
- **Dispatcher contract:** do not assert `dispatch_i` while `full_o`=1. `FULL_MARGIN` cycles of pipeline slack are tolerated without loss.

## Test plan
- **Fill and flags:** `N_SLOTS`=4, `FULL_MARGIN`=1, `wl_ready_i`=0; push A,B,C,D on consecutive cycles.
  - `usage_o` steps 1, 2, 3, 4.
  - `full_o` rises when `usage_o` = 3.
  - `empty_o` falls after the first push.
  - `overflow_o` stays 0.
- **Overflow:** with the queue at usage 4, push E with no ready.
  - `overflow_o` = 1 and stays 1 until reset.
  - `usage_o` stays 4.
  - Then raise ready: A, B, C, D issue in order and E never appears.
- **Round-robin:** `N_SA`=3, queue holds I0..I5, `wl_ready_i`=3'b111 for 3 cycles, then 3'b101.
  - `start_o` sequence: 001, 010, 100, 001, 100, 001.
  - `issued_instr_o` matches I0..I5 in order.
- **Simultaneous push/pop at full:** usage 4 with ready=1 and `dispatch_i`=1.
  - `usage_o` stays 4, `overflow_o` stays 0.
  - The new instruction issues after the 4 older ones.
- **Flush:** usage 3, `flush_i`=1 with `dispatch_i`=1 and ready=1.
  - `start_o` = 0 that cycle.
  - Next cycle: `usage_o`=0, `empty_o`=1, `overflow_o` unchanged.
  - A subsequent push issues to the array chosen by the preserved `rr_ptr`.
- **Mid-operation reset:** usage 2, then one cycle of `rst_i`=1.
  - All outputs take their reset values on the next cycle.
  - A push one cycle later issues on the cycle after that, to array 0.
